// File: rtl/id_control_seq_pkg.sv
// Shared encodings for the ID-stage control slice: opcodes, functs, ALU ops,
// mul/div op codes, sequencer states and the ID/EX control bundle.
package id_control_seq_pkg;

  localparam logic [5:0] OP_SPECIAL  = 6'h00;
  localparam logic [5:0] OP_J        = 6'h02;
  localparam logic [5:0] OP_JAL      = 6'h03;
  localparam logic [5:0] OP_BEQ      = 6'h04;
  localparam logic [5:0] OP_BNE      = 6'h05;
  localparam logic [5:0] OP_ADDI     = 6'h08;
  localparam logic [5:0] OP_ADDIU    = 6'h09;
  localparam logic [5:0] OP_SLTI     = 6'h0A;
  localparam logic [5:0] OP_SLTIU    = 6'h0B;
  localparam logic [5:0] OP_ANDI     = 6'h0C;
  localparam logic [5:0] OP_ORI      = 6'h0D;
  localparam logic [5:0] OP_XORI     = 6'h0E;
  localparam logic [5:0] OP_LUI      = 6'h0F;
  localparam logic [5:0] OP_SPECIAL2 = 6'h1C;
  localparam logic [5:0] OP_LW       = 6'h23;
  localparam logic [5:0] OP_SW       = 6'h2B;

  localparam logic [5:0] FUNCT_SLL  = 6'h00;
  localparam logic [5:0] FUNCT_SRL  = 6'h02;
  localparam logic [5:0] FUNCT_SRA  = 6'h03;
  localparam logic [5:0] FUNCT_JR   = 6'h08;
  localparam logic [5:0] FUNCT_DIV  = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU = 6'h1B;
  localparam logic [5:0] FUNCT_ADD  = 6'h20;
  localparam logic [5:0] FUNCT_ADDU = 6'h21;
  localparam logic [5:0] FUNCT_SUB  = 6'h22;
  localparam logic [5:0] FUNCT_SUBU = 6'h23;
  localparam logic [5:0] FUNCT_AND  = 6'h24;
  localparam logic [5:0] FUNCT_OR   = 6'h25;
  localparam logic [5:0] FUNCT_XOR  = 6'h26;
  localparam logic [5:0] FUNCT_NOR  = 6'h27;
  localparam logic [5:0] FUNCT_SLT  = 6'h2A;
  localparam logic [5:0] FUNCT_SLTU = 6'h2B;
  localparam logic [5:0] FUNCT_MUL  = 6'h02;  // under SPECIAL2

  localparam logic [4:0] ALUOP_ADD  = 5'd0;
  localparam logic [4:0] ALUOP_ADDU = 5'd1;
  localparam logic [4:0] ALUOP_SUB  = 5'd2;
  localparam logic [4:0] ALUOP_SUBU = 5'd3;
  localparam logic [4:0] ALUOP_AND  = 5'd4;
  localparam logic [4:0] ALUOP_OR   = 5'd5;
  localparam logic [4:0] ALUOP_XOR  = 5'd6;
  localparam logic [4:0] ALUOP_NOR  = 5'd7;
  localparam logic [4:0] ALUOP_SLT  = 5'd8;
  localparam logic [4:0] ALUOP_SLTU = 5'd9;
  localparam logic [4:0] ALUOP_SLL  = 5'd10;
  localparam logic [4:0] ALUOP_SRL  = 5'd11;
  localparam logic [4:0] ALUOP_SRA  = 5'd12;
  localparam logic [4:0] ALUOP_LUI  = 5'd13;

  typedef enum logic [1:0] {
    MD_OP_NONE = 2'b00,
    MD_OP_MUL  = 2'b01,
    MD_OP_DIV  = 2'b10,
    MD_OP_DIVU = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    SEQ_IDLE = 2'd0,
    SEQ_RUN  = 2'd1,
    SEQ_DONE = 2'd2
  } seq_state_e;

  typedef enum logic [1:0] {
    PC_PLUS4  = 2'b00,
    PC_JUMP   = 2'b01,
    PC_BRANCH = 2'b10,
    PC_JR     = 2'b11
  } pc_sel_e;

  typedef struct packed {
    logic alu_src;
    logic reg_dst;
    logic jump_link;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic reg_write;
    logic md_sel;
  } ex_ctrl_t;

  localparam ex_ctrl_t EX_BUBBLE = '0;

endpackage

// File: rtl/id_control_seq_md_sequencer.sv
// Multi-cycle MUL/DIV sequencer: launches the datapath, counts its latency and
// tells the parent when to stall the front end and when to issue the result.
module id_control_seq_md_sequencer
  import id_control_seq_pkg::*;
#(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32
) (
  input  logic   clock,
  input  logic   reset,
  input  logic   id_stall,
  input  logic   md_req,
  input  md_op_e md_req_op,
  output logic   md_stall,
  output logic   md_issue,
  output logic   md_start,
  output md_op_e md_op
);

  localparam logic [7:0] MUL_CNT = 8'(MUL_CYCLES);
  localparam logic [7:0] DIV_CNT = 8'(DIV_CYCLES);

  seq_state_e state_reg, state_next;
  logic [7:0] cnt_reg, cnt_next;
  logic       md_start_reg, md_start_next;
  md_op_e     md_op_reg, md_op_next;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg    <= SEQ_IDLE;
      cnt_reg      <= 8'd0;
      md_start_reg <= 1'b0;
      md_op_reg    <= MD_OP_NONE;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      md_start_reg <= md_start_next;
      md_op_reg    <= md_op_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    md_start_next = 1'b0;
    md_op_next    = md_op_reg;
    md_stall      = 1'b0;
    md_issue      = 1'b0;
    case (state_reg)
      SEQ_IDLE: begin
        // An externally stalled MD instruction waits in ID without launching.
        if (md_req && !id_stall) begin
          md_stall      = 1'b1;
          md_start_next = 1'b1;
          md_op_next    = md_req_op;
          cnt_next      = (md_req_op == MD_OP_MUL) ? MUL_CNT : DIV_CNT;
          state_next    = SEQ_RUN;
        end
      end
      SEQ_RUN: begin
        md_stall = 1'b1;
        if (cnt_reg == 8'd1) begin
          state_next = SEQ_DONE;
        end else begin
          cnt_next = cnt_reg - 8'd1;
        end
      end
      SEQ_DONE: begin
        // md_op stays valid until the result is actually handed to EX.
        if (!id_stall) begin
          md_issue   = 1'b1;
          md_op_next = MD_OP_NONE;
          state_next = SEQ_IDLE;
        end
      end
      default: begin
        state_next = SEQ_IDLE;
      end
    endcase
  end

  assign md_start = md_start_reg;
  assign md_op    = md_op_reg;

endmodule

// File: rtl/id_control_seq.sv
// ID-stage control: instruction decode, PC source select, MUL/DIV front-end
// sequencing and the registered ID/EX control slice.
module id_control_seq
  import id_control_seq_pkg::*;
#(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32,
  parameter int DELAY_SLOT = 1,
  parameter int ALUOP_W    = 5
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               id_stall,
  input  logic [5:0]         id_opcode,
  input  logic [5:0]         id_funct,
  input  logic               id_cmp_eq,
  output logic [1:0]         id_pc_source_sel,
  output logic               id_sign_extend,
  output logic               if_flush,
  output logic               id_md_stall,
  output logic               id_illegal,
  output logic               err_illegal,
  output logic               md_start,
  output logic [1:0]         md_op,
  output logic [ALUOP_W-1:0] ex_alu_op,
  output logic               ex_alu_src,
  output logic               ex_reg_dst,
  output logic               ex_jump_link,
  output logic               ex_mem_read,
  output logic               ex_mem_write,
  output logic               ex_mem_to_reg,
  output logic               ex_reg_write,
  output logic               ex_md_sel
);

  localparam logic [ALUOP_W-1:0] ALU_BUBBLE = ALUOP_W'(ALUOP_ADDU);

  ex_ctrl_t   dec_ctrl;
  logic [4:0] dec_alu;
  logic       dec_legal, dec_md_req;
  md_op_e     dec_md_op;
  logic       is_beq, is_bne, is_j, is_jr;

  always_comb begin
    dec_ctrl   = EX_BUBBLE;
    dec_alu    = ALUOP_ADDU;
    dec_legal  = 1'b1;
    dec_md_req = 1'b0;
    dec_md_op  = MD_OP_NONE;
    is_beq     = 1'b0;
    is_bne     = 1'b0;
    is_j       = 1'b0;
    is_jr      = 1'b0;
    case (id_opcode)
      OP_SPECIAL: begin
        dec_ctrl.reg_dst   = 1'b1;
        dec_ctrl.reg_write = 1'b1;
        case (id_funct)
          FUNCT_ADD:  dec_alu = ALUOP_ADD;
          FUNCT_ADDU: dec_alu = ALUOP_ADDU;
          FUNCT_SUB:  dec_alu = ALUOP_SUB;
          FUNCT_SUBU: dec_alu = ALUOP_SUBU;
          FUNCT_AND:  dec_alu = ALUOP_AND;
          FUNCT_OR:   dec_alu = ALUOP_OR;
          FUNCT_XOR:  dec_alu = ALUOP_XOR;
          FUNCT_NOR:  dec_alu = ALUOP_NOR;
          FUNCT_SLT:  dec_alu = ALUOP_SLT;
          FUNCT_SLTU: dec_alu = ALUOP_SLTU;
          FUNCT_SLL:  dec_alu = ALUOP_SLL;
          FUNCT_SRL:  dec_alu = ALUOP_SRL;
          FUNCT_SRA:  dec_alu = ALUOP_SRA;
          FUNCT_JR: begin
            dec_ctrl = EX_BUBBLE;
            is_jr    = 1'b1;
          end
          FUNCT_DIV, FUNCT_DIVU: begin
            dec_ctrl   = EX_BUBBLE;
            dec_md_req = 1'b1;
            dec_md_op  = (id_funct == FUNCT_DIV) ? MD_OP_DIV : MD_OP_DIVU;
          end
          default: begin
            dec_ctrl  = EX_BUBBLE;
            dec_legal = 1'b0;
          end
        endcase
      end
      OP_SPECIAL2: begin
        if (id_funct == FUNCT_MUL) begin
          dec_md_req = 1'b1;
          dec_md_op  = MD_OP_MUL;
        end else begin
          dec_legal = 1'b0;
        end
      end
      OP_J:   is_j = 1'b1;
      OP_JAL: begin
        is_j               = 1'b1;
        dec_ctrl.jump_link = 1'b1;
        dec_ctrl.reg_write = 1'b1;
      end
      OP_BEQ: begin
        is_beq  = 1'b1;
        dec_alu = ALUOP_SUBU;
      end
      OP_BNE: begin
        is_bne  = 1'b1;
        dec_alu = ALUOP_SUBU;
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        dec_ctrl.alu_src   = 1'b1;
        dec_ctrl.reg_write = 1'b1;
        case (id_opcode)
          OP_ADDI:  dec_alu = ALUOP_ADD;
          OP_SLTI:  dec_alu = ALUOP_SLT;
          OP_SLTIU: dec_alu = ALUOP_SLTU;
          OP_ANDI:  dec_alu = ALUOP_AND;
          OP_ORI:   dec_alu = ALUOP_OR;
          OP_XORI:  dec_alu = ALUOP_XOR;
          OP_LUI:   dec_alu = ALUOP_LUI;
          default:  dec_alu = ALUOP_ADDU;
        endcase
      end
      OP_LW: begin
        dec_ctrl.alu_src    = 1'b1;
        dec_ctrl.mem_read   = 1'b1;
        dec_ctrl.mem_to_reg = 1'b1;
        dec_ctrl.reg_write  = 1'b1;
      end
      OP_SW: begin
        dec_ctrl.alu_src   = 1'b1;
        dec_ctrl.mem_write = 1'b1;
      end
      default: dec_legal = 1'b0;
    endcase
  end

  logic   md_issue;
  md_op_e seq_md_op;

  id_control_seq_md_sequencer #(
    .MUL_CYCLES(MUL_CYCLES),
    .DIV_CYCLES(DIV_CYCLES)
  ) u_md_sequencer (
    .clock    (clock),
    .reset    (reset),
    .id_stall (id_stall),
    .md_req   (dec_md_req),
    .md_req_op(dec_md_op),
    .md_stall (id_md_stall),
    .md_issue (md_issue),
    .md_start (md_start),
    .md_op    (seq_md_op)
  );

  assign md_op          = seq_md_op;
  assign id_sign_extend = (id_opcode[5:2] != 4'b0011);
  assign id_illegal     = !dec_legal && !id_stall && !id_md_stall;

  // Control transfers only resolve when ID is actually advancing.
  pc_sel_e pc_sel;
  always_comb begin
    pc_sel = PC_PLUS4;
    if (!id_stall && !id_md_stall) begin
      if ((is_beq && id_cmp_eq) || (is_bne && !id_cmp_eq)) pc_sel = PC_BRANCH;
      else if (is_j)                                        pc_sel = PC_JUMP;
      else if (is_jr)                                       pc_sel = PC_JR;
    end
  end
  assign id_pc_source_sel = pc_sel;

  generate
    if (DELAY_SLOT == 0) begin : g_flush
      assign if_flush = (pc_sel != PC_PLUS4);
    end else begin : g_delay_slot
      assign if_flush = 1'b0;
    end
  endgenerate

  ex_ctrl_t            ex_ctrl_reg, ex_ctrl_next;
  logic [ALUOP_W-1:0]  ex_alu_reg, ex_alu_next;
  logic                err_illegal_reg;

  always_comb begin
    ex_ctrl_next = EX_BUBBLE;
    ex_alu_next  = ALU_BUBBLE;
    if (md_issue) begin
      // MUL writes the register file through the md result mux; DIV results land in HI/LO.
      ex_ctrl_next.md_sel    = 1'b1;
      ex_ctrl_next.reg_write = (seq_md_op == MD_OP_MUL);
      ex_ctrl_next.reg_dst   = (seq_md_op == MD_OP_MUL);
    end else if (!id_stall && !id_md_stall && dec_legal && !dec_md_req) begin
      ex_ctrl_next = dec_ctrl;
      ex_alu_next  = ALUOP_W'(dec_alu);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ex_ctrl_reg     <= EX_BUBBLE;
      ex_alu_reg      <= ALU_BUBBLE;
      err_illegal_reg <= 1'b0;
    end else begin
      ex_ctrl_reg     <= ex_ctrl_next;
      ex_alu_reg      <= ex_alu_next;
      err_illegal_reg <= err_illegal_reg | id_illegal;
    end
  end

  assign err_illegal   = err_illegal_reg;
  assign ex_alu_op     = ex_alu_reg;
  assign ex_alu_src    = ex_ctrl_reg.alu_src;
  assign ex_reg_dst    = ex_ctrl_reg.reg_dst;
  assign ex_jump_link  = ex_ctrl_reg.jump_link;
  assign ex_mem_read   = ex_ctrl_reg.mem_read;
  assign ex_mem_write  = ex_ctrl_reg.mem_write;
  assign ex_mem_to_reg = ex_ctrl_reg.mem_to_reg;
  assign ex_reg_write  = ex_ctrl_reg.reg_write;
  assign ex_md_sel     = ex_ctrl_reg.md_sel;

endmodule
